exec_issue_arb: RTL
===================

EXEC_ISSUE_ARB -- requirements
Module: exec_issue_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of issue requesters (0=branch RS, 1=ALU RS, 2=load queue); legal range 2..8.
REQ-002 SHALL have parameter PAYLOAD_W, default 128, width of opaque issue bundle (pc, imm, ctrl, operands, rd_p, rob tag).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  kill held issue bundle.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester valid.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_payload_i  input  NUM_REQ*PAYLOAD_W  requester i bundle at bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-009 SHALL have port ex_valid_o  output  1  bundle valid toward execute unit.
REQ-010 SHALL have port ex_ready_i  input  1  execute unit accepts.
REQ-011 SHALL have port ex_payload_o  output  PAYLOAD_W  held bundle.
REQ-012 SHALL have port ex_src_o  output  $clog2(NUM_REQ)  index of requester that supplied held bundle.

Function
REQ-013 SHALL hold one bundle in an output slot with states EMPTY and FULL; ex_valid_o = (state == FULL).
REQ-014 Slot can accept (can_acc) when EMPTY, or FULL with ex_ready_i = 1 (same-cycle drain and refill); can_acc SHALL be 0 when flush_i = 1.
REQ-015 Grant: round-robin search over valid requesters starting at pointer rr_ptr, ascending, wrapping NUM_REQ-1 -> 0; req_ready_o[g] = can_acc for the winner g only, all other bits 0.
REQ-016 On handshake (req_valid_i[g] && req_ready_o[g]) slot SHALL load req_payload_i slice g and ex_src_o = g, state FULL next cycle; latency request-to-ex_valid_o exactly 1 cycle.
REQ-017 On handshake rr_ptr SHALL become (g+1) mod NUM_REQ; with no handshake rr_ptr SHALL be unchanged.
REQ-018 FULL with ex_ready_i = 1 and no new grant SHALL go EMPTY next cycle.
REQ-019 While FULL and ex_ready_i = 0, ex_payload_o and ex_src_o SHALL be stable and req_ready_o SHALL be all zero.
REQ-020 req_ready_o SHALL NOT depend combinationally on req_payload_i; it MAY depend on req_valid_i, ex_ready_i, flush_i.
REQ-021 flush_i = 1 SHALL force EMPTY next cycle regardless of ex_ready_i, accept no request that cycle, and leave rr_ptr unchanged; flush has priority over a same-cycle drain.
REQ-022 No requester valid and slot EMPTY: state remains EMPTY, outputs hold last payload/src values (don't-care to consumer).

Reset
REQ-023 rst_n low SHALL asynchronously set state EMPTY, ex_valid_o = 0, rr_ptr = 0, ex_src_o = 0, ex_payload_o = 0; req_ready_o = 0 while rst_n low.
REQ-024 Reset mid-transfer SHALL discard the held bundle; first grant after release SHALL start search at requester 0.

Configuration
REQ-025 Macro EXEC_ARB_BRANCH_PRIO_EN defined: requester 0 (branch) SHALL win whenever req_valid_i[0] = 1, overriding round robin; a priority grant SHALL NOT update rr_ptr; other requesters use REQ-015/017.
REQ-026 Macro EXEC_ARB_BRANCH_PRIO_EN undefined: pure round robin across all requesters per REQ-015/017, requester 0 has no special priority.

Verification
REQ-027 All three valid every cycle, ex_ready_i = 1, macro off -> ex_src_o sequence 0,1,2,0,1,2, one bundle per cycle, ex_valid_o held 1.
REQ-028 Requester 1 valid with payload 0xA5.., ex_ready_i = 0 for 4 cycles -> ex_valid_o = 1 one cycle after accept, payload stable, req_ready_o = 000 for those 4 cycles, drains on ex_ready_i = 1.
REQ-029 FULL, ex_ready_i = 1, flush_i = 1, requester 2 valid -> next cycle ex_valid_o = 0, req_ready_o = 000 during flush cycle, rr_ptr unchanged.
REQ-030 Macro on, requesters 0 and 1 valid continuously, ex_ready_i = 1 -> ex_src_o = 0 every cycle; drop req 0 -> next grant is requester 1 (rr_ptr still 0 start, 0 invalid).
REQ-031 rst_n asserted while FULL -> ex_valid_o = 0 immediately (no clock edge); after release with all valid, first ex_src_o = 0.
REQ-032 Random valid/ready/flush for 10k cycles -> req_ready_o one-hot-or-zero, no bundle lost or duplicated except flush-killed, scoreboard matches order.

Source files
------------

// File: rtl/exec_issue_arb.sv
// Single-slot issue arbiter: round-robin grant among NUM_REQ requesters into one held bundle.
// Optional macro EXEC_ARB_BRANCH_PRIO_EN gives requester 0 (branch) absolute priority.
module exec_issue_arb #(
  parameter int NUM_REQ   = 3,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload_i,
  output logic                           ex_valid_o,
  input  logic                           ex_ready_i,
  output logic [PAYLOAD_W-1:0]           ex_payload_o,
  output logic [$clog2(NUM_REQ)-1:0]     ex_src_o
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  logic                 can_acc_s;
  logic                 found_s;
  logic                 prio_s;
  logic                 hs_s;
  logic [SRC_W-1:0]     grant_s;
  logic [NUM_REQ-1:0]   ready_s;
  int                   best_d_s;
  int                   dist_s;

  // Slot can take a bundle when empty or draining this cycle; never during flush or reset.
  always_comb begin
    can_acc_s = rst_n && !flush_i && ((state_q == ST_EMPTY) || ex_ready_i);
  end

  // Winner is the valid requester closest to rr_ptr going upward with wrap.
  always_comb begin
    found_s  = 1'b0;
    prio_s   = 1'b0;
    grant_s  = '0;
    best_d_s = NUM_REQ;
    dist_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = i - int'(rr_ptr_q);
      if (dist_s < 0) begin
        dist_s = dist_s + NUM_REQ;
      end else begin
        dist_s = dist_s;
      end
      if (req_valid_i[i] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        grant_s  = SRC_W'(i);
        found_s  = 1'b1;
      end else begin
        best_d_s = best_d_s;
      end
    end
`ifdef EXEC_ARB_BRANCH_PRIO_EN
    if (req_valid_i[0]) begin
      found_s = 1'b1;
      grant_s = '0;
      prio_s  = 1'b1;
    end else begin
      prio_s  = 1'b0;
    end
`endif
  end

  // Ready goes only to the winner; it never looks at payload bits.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = can_acc_s && found_s && (grant_s == SRC_W'(i));
    end
    hs_s = can_acc_s && found_s;
  end

  // Slot and pointer next-state; flush outranks both refill and drain.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    src_d     = src_q;
    payload_d = payload_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (hs_s) begin
      state_d   = ST_FULL;
      src_d     = grant_s;
      payload_d = req_payload_i[int'(grant_s)*PAYLOAD_W +: PAYLOAD_W];
      if (prio_s) begin
        rr_ptr_d = rr_ptr_q;
      end else if (grant_s == SRC_W'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_s + SRC_W'(1);
      end
    end else begin
      case (state_q)
        ST_FULL:  state_d = ex_ready_i ? ST_EMPTY : ST_FULL;
        ST_EMPTY: state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      rr_ptr_q  <= '0;
      src_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      src_q     <= src_d;
      payload_q <= payload_d;
    end
  end

  assign req_ready_o  = ready_s;
  assign ex_valid_o   = (state_q == ST_FULL);
  assign ex_payload_o = payload_q;
  assign ex_src_o     = src_q;

endmodule
